lsu_banked_hs: RTL
==================

Name: lsu_banked_hs

Overview:
- Next-generation load/store unit fronting a byte-lane banked data RAM, with a valid/ready request and response handshake.
- Generalised to 32- or 64-bit data, and parametrised in bank depth and misalignment policy.
- Supports all RISC-V load/store widths with sign/zero extension.
- Misaligned accesses either return a fault or are split into two RAM beats.
- Sits between the core's MEM stage and data memory.
- One outstanding request at a time.

Parameters:
- DATA_WIDTH, 32, data bus width; legal values 32 or 64. LANES = DATA_WIDTH/8.
- DEPTH, 1024, rows per byte-lane bank. ADDR_WIDTH = $clog2(DEPTH*LANES) is a byte address and is derived, not overridable.
- MISALIGN_MODE, 0, access policy: 0 = fault on misaligned access, 1 = split into two beats.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_we  in  1  1 = store, 0 = load
- req_dtype  in  3  access type:
  - 000 B, 001 H, 010 W, 011 BU, 100 HU, 101 WU, 110 D
  - WU and D are legal only when DATA_WIDTH = 64
  - 111 is reserved
- req_wdata  in  DATA_WIDTH  store data, LSB-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_WIDTH  load result after extension; 0 for stores and errors
- rsp_err  out  1  misaligned (mode 0) or illegal dtype
- Clock/reset: reset reset_n, synchronous, active-low; clock clk.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers cleared. RAM contents are not reset.
- Memory layout is little-endian.
  - row = addr >> log2(LANES); off = addr mod LANES; size = 1/2/4/8 bytes.
  - Byte k of the access maps to lane (off+k) mod LANES.
- Accept: a request is taken on a clk edge with req_valid & req_ready. req_ready=1 only in IDLE, so there is no pipelining across requests.
- FSM states: IDLE, ACC0, ACC1, WAIT, RESP.
- IDLE, on accept: capture addr/we/dtype/wdata.
  - Illegal dtype, or misaligned with MISALIGN_MODE=0: go to RESP with rsp_err=1, rdata=0. No RAM access; response is visible 1 cycle after the accept edge.
  - Otherwise: go to ACC0.
- Misaligned means off+size > LANES. Natural misalignment inside a row (e.g. LH at off 1) is legal and done in one beat.
- ACC0: drive row, lane write enables and lane-rotated write data. Stores write only the addressed lanes, never others.
  - If the access crosses a row (mode 1): go to ACC1.
  - Otherwise: go to WAIT.
- ACC1: access row+1, lanes 0..(off+size-LANES-1).
  - Row wraps: DEPTH-1 + 1 = 0.
  - Beat-0 read lanes are held in a staging register.
- WAIT: RAM has 1-cycle synchronous read. Assemble bytes, apply extension, register rsp_rdata, go to RESP.
  - B/H/W: sign-extend from the top byte of the access.
  - BU/HU/WU: zero-extend.
  - Stores return rdata=0.
- Latency from the accept edge to rsp_valid high:
  - 3 cycles for a single beat.
  - 4 cycles for a split access.
  - 1 cycle for an error.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE.
  - rsp_valid drops on the cycle after the handshake.
  - req_ready rises in the same cycle.
- Stores complete into RAM before rsp_valid is asserted.
- Reset asserted in any state: go to IDLE on that edge, all outputs at reset values. A pending ACC1 beat is abandoned; a split store may leave only beat 0 written.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg:
  - dtype_e enum with the 3-bit codes above.
  - state_e enum.
  - Function dtype_size(dtype_e) returning the size in bytes.
  - Function dtype_signed(dtype_e).
- Sub-module lsu_lane_ram:
  - LANES independent byte banks of DEPTH rows each.
  - Shared row address, per-lane write enable, 1-cycle registered read.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 3 cycles after each accept.
- Loads after the first test's store (memory holds 0xDEADBEEF @0x010):
  - LB @0x013 -> 0xFFFFFFDE
  - LBU @0x013 -> 0x000000DE
  - LH @0x012 -> 0xFFFFDEAD
  - LHU @0x012 -> 0x0000DEAD
- MISALIGN_MODE=0:
  - SW 0x0 @0x011 -> rsp_err=1 at +1 cycle.
  - Then LW @0x010 -> still 0xDEADBEEF (no write occurred).
  - dtype 111 -> rsp_err=1.
- MISALIGN_MODE=1:
  - SW 0x11223344 @0x0FE, then LBU @0x0FE/0x0FF/0x100/0x101 -> 0x44/0x33/0x22/0x11.
  - LW @0x0FE -> 0x11223344, latency 4.
  - SH 0xABCD @0xFFF -> LBU @0xFFF = 0xCD, LBU @0x000 = 0xAB (row wrap).
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; handshake then returns to IDLE.
- Reset mid-operation: assert reset_n=0 while in ACC1 of a split SW @0x0FE -> next cycle rsp_valid=0, req_ready=1; LBU @0x100 returns its prior value.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and access-size helpers for the banked load/store unit
package lsu_pkg;

   typedef enum logic [2:0] {
      DT_B   = 3'b000,
      DT_H   = 3'b001,
      DT_W   = 3'b010,
      DT_BU  = 3'b011,
      DT_HU  = 3'b100,
      DT_WU  = 3'b101,
      DT_D   = 3'b110,
      DT_RSV = 3'b111
   } dtype_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC0,
      S_ACC1,
      S_WAIT,
      S_RESP
   } state_e;

   function automatic int dtype_size(dtype_e dt);
      case (dt)
         DT_H, DT_HU: return 2;
         DT_W, DT_WU: return 4;
         DT_D:        return 8;
         default:     return 1;
      endcase
   endfunction

   function automatic logic dtype_signed(dtype_e dt);
      return dt inside {DT_B, DT_H, DT_W};
   endfunction

endpackage

// File: rtl/lsu_lane_ram.sv
// rtl/lsu_lane_ram.sv - byte-lane banked RAM, shared row address, 1-cycle registered read
module lsu_lane_ram #(
   parameter int LANES = 4,
   parameter int DEPTH = 1024,
   parameter int RW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic [RW-1:0]      row,
   input  logic [LANES-1:0]   we,
   input  logic [LANES*8-1:0] wdata,
   output logic [LANES*8-1:0] rdata
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (we[l]) begin
            mem[row] <= wdata[l*8 +: 8];
         end
         rd_q <= mem[row];
      end

      assign rdata[l*8 +: 8] = rd_q;
   end

endmodule

// File: rtl/lsu_banked_hs.sv
// rtl/lsu_banked_hs.sv - single-outstanding load/store unit over a byte-lane banked RAM
module lsu_banked_hs
   import lsu_pkg::*;
#(
   parameter int  DATA_WIDTH    = 32,
   parameter int  DEPTH         = 1024,
   parameter int  MISALIGN_MODE = 0,
   localparam int LANES         = DATA_WIDTH / 8,
   localparam int ADDR_WIDTH    = $clog2(DEPTH * LANES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_we,
   input  logic [2:0]            req_dtype,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int LB = $clog2(LANES);
   localparam int RW = ADDR_WIDTH - LB;

   state_e                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   dtype_e                dtype_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] stage_q;

   dtype_e                req_dt;
   int                    req_off;
   logic                  req_err;
   int                    off;
   int                    size;
   logic                  split;
   logic [RW-1:0]         row0, row1, ram_row;
   logic [LANES-1:0]      ram_we;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
   logic [DATA_WIDTH-1:0] beat0, gathered, load_data;
   logic                  sign;

   function automatic logic dtype_legal(dtype_e dt);
      return (dt != DT_RSV) && (DATA_WIDTH == 64 || !(dt inside {DT_WU, DT_D}));
   endfunction

   always_comb begin
      req_dt  = dtype_e'(req_dtype);
      req_off = int'(req_addr[LB-1:0]);
      req_err = !dtype_legal(req_dt) ||
                (MISALIGN_MODE == 0 && (req_off + dtype_size(req_dt)) > LANES);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_err ? S_RESP : S_ACC0;
            end
         end
         S_ACC0:  state_nxt = split ? S_ACC1 : S_WAIT;
         S_ACC1:  state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_RESP;
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Beat 0 covers lanes off..LANES-1 of row0, beat 1 wraps onto lanes 0.. of the next row.
   // Write enables are gated by reset so an abandoned ACC1 beat never lands in RAM.
   always_comb begin
      off       = int'(addr_q[LB-1:0]);
      size      = dtype_size(dtype_q);
      split     = (off + size) > LANES;
      row0      = addr_q[ADDR_WIDTH-1:LB];
      row1      = (row0 == RW'(DEPTH - 1)) ? '0 : row0 + RW'(1);
      ram_row   = (state == S_ACC1) ? row1 : row0;
      ram_we    = '0;
      ram_wdata = '0;
      for (int l = 0; l < LANES; l++) begin
         ram_wdata[l*8 +: 8] = wdata_q[((l + LANES - off) % LANES)*8 +: 8];
         if (we_q && reset_n) begin
            if (state == S_ACC0) ram_we[l] = (l >= off) && ((l - off) < size);
            if (state == S_ACC1) ram_we[l] = l < (off + size - LANES);
         end
      end
   end

   always_comb begin
      beat0    = split ? stage_q : ram_rdata;
      gathered = '0;
      for (int b = 0; b < LANES; b++) begin
         if (off + b >= LANES) gathered[b*8 +: 8] = ram_rdata[((off + b) % LANES)*8 +: 8];
         else                  gathered[b*8 +: 8] = beat0[(off + b)*8 +: 8];
      end
      sign      = dtype_signed(dtype_q) && gathered[(size - 1)*8 + 7];
      load_data = '0;
      for (int b = 0; b < LANES; b++) begin
         load_data[b*8 +: 8] = (b < size) ? gathered[b*8 +: 8] : {8{sign}};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q    <= '0;
         we_q      <= 1'b0;
         dtype_q   <= DT_B;
         wdata_q   <= '0;
         stage_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  we_q    <= req_we;
                  dtype_q <= req_dt;
                  wdata_q <= req_wdata;
                  if (req_err) begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            S_ACC1: stage_q <= ram_rdata;
            S_WAIT: begin
               rsp_rdata <= we_q ? '0 : load_data;
               rsp_err   <= 1'b0;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   lsu_lane_ram #(
      .LANES(LANES),
      .DEPTH(DEPTH),
      .RW   (RW)
   ) u_ram (
      .clk  (clk),
      .row  (ram_row),
      .we   (ram_we),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

endmodule
